t08_mmio_ctrl: RTL and testbench

Registered, parametrised memory-mapped I/O controller between the memory handler and the SPI, I2C and wishbone data-memory ports. Requests are latched into a state machine that runs the peripheral handshakes itself, so the requester issues one strobe and waits for a done pulse. An optional watchdog aborts stalled transactions with an error flag.

---
 rtl/t08_mmio_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_t08_mmio_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/t08_mmio_ctrl.sv
// Memory-mapped I/O controller: one request strobe in, one done pulse out; runs the
// data-memory, SPI and I2C handshakes itself. Optional watchdog: define MMIO_TIMEOUT_EN.
module t08_mmio_ctrl #(
  parameter int DATA_W         = 32,
  parameter int MEM_LIMIT      = 2048,
  parameter int SPI_CMD_ADDR   = 121212,
  parameter int SPI_PARAM_ADDR = 333333,
  parameter int I2C_ADDR       = 923923,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic              write,
  input  logic              getinst,
  input  logic [DATA_W-1:0] address,
  input  logic [DATA_W-1:0] mh_data_i,
  input  logic [31:0]       I2C_xy_i,
  input  logic              I2C_done_i,
  input  logic              spi_busy_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_busy_i,
  output logic [DATA_W-1:0] mh_data_o,
  output logic              mmio_busy_o,
  output logic              mmio_done_o,
  output logic              mmio_err_o,
  output logic              I2C_done_o,
  output logic [31:0]       spi_parameters_o,
  output logic [7:0]        spi_command_o,
  output logic [3:0]        spi_counter_o,
  output logic              spi_read_o,
  output logic              spi_write_o,
  output logic              spi_enable_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic [DATA_W-1:0] mem_address_o,
  output logic [3:0]        mem_select_o,
  output logic              mem_write_o,
  output logic              mem_read_o,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MEM_ISSUE = 3'd1,
    MEM_BUSY  = 3'd2,
    SPI_WAIT  = 3'd3,
    I2C_WAIT  = 3'd4,
    DONE      = 3'd5
  } state_t;

  localparam logic [DATA_W-1:0] MEM_LIM   = DATA_W'(MEM_LIMIT);
  localparam logic [DATA_W-1:0] SPI_CMD   = DATA_W'(SPI_CMD_ADDR);
  localparam logic [DATA_W-1:0] SPI_PARAM = DATA_W'(SPI_PARAM_ADDR);
  localparam logic [DATA_W-1:0] I2C_REG   = DATA_W'(I2C_ADDR);
  localparam logic [DATA_W-1:0] BAD_DATA  = DATA_W'(32'hBAD1BAD1);

  state_t            state, state_n;
  logic [DATA_W-1:0] data_q, data_n;
  logic [DATA_W-1:0] mh_data_n, mem_data_n, mem_address_n;
  logic [31:0]       spi_parameters_n;
  logic [7:0]        spi_command_n;
  logic [3:0]        spi_counter_n;
  logic              mem_write_n, mem_read_n, spi_write_n, err_n;
  logic              is_rd, wd_expire, abort;

`ifdef MMIO_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);
  logic [15:0] wd_cnt;

  // Every wait state is entered from IDLE, so holding the count at zero there and in
  // DONE is the same as clearing it on entry; MEM_ISSUE and MEM_BUSY share the count.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE || state == DONE) wd_cnt <= 16'd0;
    else                                       wd_cnt <= wd_cnt + 16'd1;
  end

  assign wd_expire = (wd_cnt == TO_LIM - 16'd1);
`else
  // Without the watchdog a wait never expires.
  assign wd_expire = (TIMEOUT_CYCLES < 0);
`endif

  assign is_rd = read | getinst;

  always_comb begin
    state_n          = state;
    data_n           = data_q;
    mh_data_n        = mh_data_o;
    mem_data_n       = mem_data_o;
    mem_address_n    = mem_address_o;
    spi_parameters_n = spi_parameters_o;
    spi_command_n    = spi_command_o;
    spi_counter_n    = spi_counter_o;
    mem_write_n      = mem_write_o;
    mem_read_n       = mem_read_o;
    spi_write_n      = 1'b0;
    err_n            = 1'b0;
    abort            = 1'b0;
    case (state)
      IDLE: begin
        if (is_rd || write) begin
          data_n = mh_data_i;
          if (is_rd && write) begin
            err_n = 1'b1; state_n = DONE;
          end else if (is_rd && address == I2C_REG) begin
            state_n = I2C_WAIT;
          end else if (address < MEM_LIM) begin
            mem_address_n = address;
            state_n       = MEM_ISSUE;
            if (is_rd) begin
              mem_read_n = 1'b1;
            end else begin
              mem_write_n = 1'b1;
              mem_data_n  = mh_data_i;
            end
          end else if (write && address == SPI_CMD) begin
            spi_command_n = mh_data_i[7:0];
            spi_counter_n = mh_data_i[11:8];
            state_n       = DONE;
          end else if (write && address == SPI_PARAM) begin
            state_n = SPI_WAIT;
          end else begin
            err_n = 1'b1; state_n = DONE;
          end
        end
      end
      MEM_ISSUE: begin
        if (mem_busy_i)     state_n = MEM_BUSY;
        else if (wd_expire) abort   = 1'b1;
      end
      MEM_BUSY: begin
        if (!mem_busy_i) begin
          if (mem_read_o) mh_data_n = mem_data_i;
          mem_read_n  = 1'b0;
          mem_write_n = 1'b0;
          state_n     = DONE;
        end else if (wd_expire) begin
          abort = 1'b1;
        end
      end
      SPI_WAIT: begin
        if (!spi_busy_i) begin
          spi_parameters_n = 32'(data_q);
          spi_write_n      = 1'b1;
          state_n          = DONE;
        end else if (wd_expire) begin
          abort = 1'b1;
        end
      end
      I2C_WAIT: begin
        if (I2C_done_i) begin
          mh_data_n = DATA_W'(I2C_xy_i);
          state_n   = DONE;
        end else if (wd_expire) begin
          abort = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort) begin
      mem_read_n  = 1'b0;
      mem_write_n = 1'b0;
      mh_data_n   = BAD_DATA;
      err_n       = 1'b1;
      state_n     = DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      data_q           <= '0;
      mh_data_o        <= '0;
      mem_data_o       <= '0;
      mem_address_o    <= '0;
      spi_parameters_o <= '0;
      spi_command_o    <= '0;
      spi_counter_o    <= '0;
      mem_write_o      <= 1'b0;
      mem_read_o       <= 1'b0;
      spi_write_o      <= 1'b0;
      mmio_err_o       <= 1'b0;
    end else begin
      state            <= state_n;
      data_q           <= data_n;
      mh_data_o        <= mh_data_n;
      mem_data_o       <= mem_data_n;
      mem_address_o    <= mem_address_n;
      spi_parameters_o <= spi_parameters_n;
      spi_command_o    <= spi_command_n;
      spi_counter_o    <= spi_counter_n;
      mem_write_o      <= mem_write_n;
      mem_read_o       <= mem_read_n;
      spi_write_o      <= spi_write_n;
      mmio_err_o       <= err_n;
    end
  end

  assign mmio_done_o  = (state == DONE);
  assign mmio_busy_o  = (state != IDLE);
  assign spi_enable_o = spi_write_o;
  assign spi_read_o   = 1'b0;
  assign mem_select_o = 4'hF;
  assign I2C_done_o   = I2C_done_i;
  assign dbg_state    = state;

endmodule

// File: tb/tb_t08_mmio_ctrl.sv
// Directed bench for t08_mmio_ctrl: hand-computed vectors for SPI, memory, I2C, error
// decoding, ignored requests and reset; watchdog vectors when MMIO_TIMEOUT_EN is defined.
module tb_t08_mmio_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read = 1'b0, write = 1'b0, getinst = 1'b0;
  logic [31:0] address = '0, mh_data_i = '0, I2C_xy_i = '0, mem_data_i = '0;
  logic        I2C_done_i = 1'b0, spi_busy_i = 1'b0, mem_busy_i = 1'b0;
  logic [31:0] mh_data_o, spi_parameters_o, mem_data_o, mem_address_o;
  logic        mmio_busy_o, mmio_done_o, mmio_err_o, I2C_done_o;
  logic [7:0]  spi_command_o;
  logic [3:0]  spi_counter_o, mem_select_o;
  logic        spi_read_o, spi_write_o, spi_enable_o, mem_write_o, mem_read_o;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

`ifdef MMIO_TIMEOUT_EN
  localparam int I2C_WAIT_CYC = 5;
`else
  localparam int I2C_WAIT_CYC = 10;
`endif

  t08_mmio_ctrl #(.DATA_W(32), .MEM_LIMIT(2048), .SPI_CMD_ADDR(121212),
    .SPI_PARAM_ADDR(333333), .I2C_ADDR(923923), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .read(read), .write(write), .getinst(getinst),
    .address(address), .mh_data_i(mh_data_i), .I2C_xy_i(I2C_xy_i),
    .I2C_done_i(I2C_done_i), .spi_busy_i(spi_busy_i), .mem_data_i(mem_data_i),
    .mem_busy_i(mem_busy_i), .mh_data_o(mh_data_o), .mmio_busy_o(mmio_busy_o),
    .mmio_done_o(mmio_done_o), .mmio_err_o(mmio_err_o), .I2C_done_o(I2C_done_o),
    .spi_parameters_o(spi_parameters_o), .spi_command_o(spi_command_o),
    .spi_counter_o(spi_counter_o), .spi_read_o(spi_read_o), .spi_write_o(spi_write_o),
    .spi_enable_o(spi_enable_o), .mem_data_o(mem_data_o), .mem_address_o(mem_address_o),
    .mem_select_o(mem_select_o), .mem_write_o(mem_write_o), .mem_read_o(mem_read_o),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic req(input logic r, input logic w, input logic g,
                     input logic [31:0] a, input logic [31:0] d);
    read = r; write = w; getinst = g; address = a; mh_data_i = d;
    tick();
    read = 1'b0; write = 1'b0; getinst = 1'b0;
  endtask

  task automatic check_done(input string tag, input logic err);
    check({tag, "_done"}, {31'd0, mmio_done_o}, 32'd1);
    check({tag, "_err"},  {31'd0, mmio_err_o},  {31'd0, err});
    check({tag, "_busy"}, {31'd0, mmio_busy_o}, 32'd1);
  endtask

  task automatic check_rdata(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_expq_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_rdata"}, mh_data_o, e);
    end
  endtask

  initial begin
    @(negedge clk);
    I2C_done_i = 1'b1;
    tick(); tick();
    check("rst_state",   {29'd0, dbg_state}, 32'd0);
    check("rst_mh_data", mh_data_o, 32'd0);
    check("rst_ctl", {mmio_busy_o, mmio_done_o, mmio_err_o, spi_write_o, spi_enable_o,
                      spi_read_o, mem_write_o, mem_read_o}, 32'd0);
    check("rst_spi", {spi_command_o, spi_counter_o} | spi_parameters_o, 32'd0);
    check("rst_mem", mem_data_o | mem_address_o, 32'd0);
    check("rst_select", {28'd0, mem_select_o}, 32'hF);
    check("rst_i2c_pass1", {31'd0, I2C_done_o}, 32'd1);
    I2C_done_i = 1'b0;
    #1 check("rst_i2c_pass0", {31'd0, I2C_done_o}, 32'd0);
    rst = 1'b0;
    tick();

    // SPI command write, latency 1
    req(1'b0, 1'b1, 1'b0, 32'd121212, 32'h0000_0A5C);
    check_done("spi_cmd", 1'b0);
    check("spi_cmd_val", {24'd0, spi_command_o}, 32'h5C);
    check("spi_cnt_val", {28'd0, spi_counter_o}, 32'hA);
    tick();
    check("spi_cmd_idle", {30'd0, mmio_done_o, mmio_busy_o}, 32'd0);

    // SPI parameter write with busy held for 5 cycles
    spi_busy_i = 1'b1;
    req(1'b0, 1'b1, 1'b0, 32'd333333, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      check("spi_wait", {29'd0, mmio_done_o, spi_write_o, mmio_busy_o}, 32'd1);
      tick();
    end
    check("spi_wait_last", {30'd0, mmio_done_o, spi_write_o}, 32'd0);
    spi_busy_i = 1'b0;
    tick();
    check_done("spi_par", 1'b0);
    check("spi_pulse", {30'd0, spi_write_o, spi_enable_o}, 32'd3);
    check("spi_params", spi_parameters_o, 32'hDEAD_BEEF);
    tick();
    check("spi_pulse_end", {30'd0, spi_write_o, spi_enable_o}, 32'd0);

    // memory read from 100
    exp_q.push_back(32'h1234_5678);
    req(1'b1, 1'b0, 1'b0, 32'd100, 32'd0);
    check("mrd_strobe", {30'd0, mem_read_o, mem_write_o}, 32'd2);
    check("mrd_addr", mem_address_o, 32'd100);
    mem_busy_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mrd_hold", {30'd0, mem_read_o, mmio_done_o}, 32'd2);
    end
    mem_busy_i = 1'b0;
    mem_data_i = 32'h1234_5678;
    tick();
    check_done("mrd", 1'b0);
    check("mrd_clr", {31'd0, mem_read_o}, 32'd0);
    check_rdata("mrd");
    tick();

    // memory write at the top of the range
    req(1'b0, 1'b1, 1'b0, 32'd2047, 32'hCAFE_F00D);
    check("mwr_strobe", {30'd0, mem_read_o, mem_write_o}, 32'd1);
    check("mwr_addr", mem_address_o, 32'd2047);
    check("mwr_data", mem_data_o, 32'hCAFE_F00D);
    mem_busy_i = 1'b1;
    tick();
    mem_busy_i = 1'b0;
    tick();
    check_done("mwr", 1'b0);
    check("mwr_clr", {31'd0, mem_write_o}, 32'd0);
    check("mwr_rdata_kept", mh_data_o, 32'h1234_5678);
    tick();

    // I2C read via getinst; a request during the wait must be ignored
    exp_q.push_back(32'h0040_0080);
    req(1'b0, 1'b0, 1'b1, 32'd923923, 32'd0);
    for (int i = 0; i < I2C_WAIT_CYC; i++) begin
      check("i2c_wait", {30'd0, mmio_busy_o, mmio_done_o}, 32'd2);
      if (i == 2) req(1'b0, 1'b1, 1'b0, 32'd121212, 32'h0000_0F11);
      else        tick();
    end
    I2C_done_i = 1'b1;
    I2C_xy_i   = 32'h0040_0080;
    tick();
    I2C_done_i = 1'b0;
    check_done("i2c", 1'b0);
    check_rdata("i2c");
    check("ignored_req", {20'd0, spi_counter_o, spi_command_o}, 32'hA5C);
    tick();

    // error decodes: unmapped write, conflict, I2C write, SPI read, MEM_LIMIT, all-ones
    req(1'b0, 1'b1, 1'b0, 32'd5000, 32'h1);
    check_done("unmapped", 1'b1);
    check("unmapped_strb", {29'd0, mem_read_o, mem_write_o, spi_write_o}, 32'd0);
    tick();
    req(1'b1, 1'b1, 1'b0, 32'd0, 32'h2);
    check_done("conflict", 1'b1);
    check("conflict_strb", {29'd0, mem_read_o, mem_write_o, spi_write_o}, 32'd0);
    check("conflict_data", mh_data_o, 32'h0040_0080);
    tick();
    req(1'b0, 1'b1, 1'b0, 32'd923923, 32'h3);
    check_done("i2c_wr", 1'b1);
    tick();
    req(1'b1, 1'b0, 1'b0, 32'd121212, 32'h0);
    check_done("spi_rd", 1'b1);
    tick();
    req(1'b1, 1'b0, 1'b0, 32'd2048, 32'h0);
    check_done("limit_rd", 1'b1);
    tick();
    req(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0);
    check_done("ones_rd", 1'b1);
    check("err_data_kept", mh_data_o, 32'h0040_0080);
    tick();
    check("err_clear", {30'd0, mmio_err_o, mmio_done_o}, 32'd0);

    // reset mid-wait: no done pulse, strobes dropped
    req(1'b1, 1'b0, 1'b0, 32'd4, 32'h0);
    tick();
    check("rstw_strobe", {31'd0, mem_read_o}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstw_state", {29'd0, dbg_state}, 32'd0);
    check("rstw_ctl", {28'd0, mem_read_o, mmio_done_o, mmio_busy_o, mmio_err_o}, 32'd0);
    tick();
    check("rstw_nodone", {31'd0, mmio_done_o}, 32'd0);

`ifdef MMIO_TIMEOUT_EN
    // watchdog abort after 8 wait cycles
    req(1'b1, 1'b0, 1'b0, 32'd4, 32'h0);
    for (int i = 0; i < 7; i++) begin
      check("wd_wait", {30'd0, mmio_done_o, mem_read_o}, 32'd1);
      tick();
    end
    tick();
    check_done("wd", 1'b1);
    check("wd_data", mh_data_o, 32'hBAD1_BAD1);
    check("wd_clr", {31'd0, mem_read_o}, 32'd0);
    tick();
    // handshake on the expiry cycle wins
    req(1'b1, 1'b0, 1'b0, 32'd4, 32'h0);
    for (int i = 0; i < 7; i++) tick();
    mem_busy_i = 1'b1;
    tick();
    check("wd_race_state", {29'd0, dbg_state}, 32'd2);
    mem_busy_i = 1'b0;
    mem_data_i = 32'h0000_0777;
    tick();
    check_done("wd_race", 1'b0);
    check("wd_race_data", mh_data_o, 32'h0000_0777);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

endmodule
